// File: rtl/fast_detect.sv
// FAST corner detector over a blurred image held in external memory.
// Pixels are visited in raster order. For each interior pixel the centre and
// the 16 pixels of the radius-3 Bresenham circle are read (17 reads), one WAIT
// cycle captures the last read, an EVAL cycle classifies the circle and a WRITE
// cycle stores the corner flag. Border pixels are written with flag 0 in one cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   new_trans                start pulse (honoured only when idle)
//   threshold, max_x, max_y  frame parameters, latched at start
//   x/y_addr_img, ren_img    image read port; rdat_img valid one cycle later
//   rdat_img                 image read data
//   x/y_addr_out, wen_out    corner-map write port; wdat_out is the flag
//   busy, det_done           activity flag and one-cycle completion pulse
//   corner_count             number of corners found in the current frame
module fast_detect #(
  parameter int X_MAX       = 200,
  parameter int Y_MAX       = 200,
  parameter int PIXEL_DEPTH = 8,
  parameter int ARC_LEN     = 9
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               new_trans,
  input  logic [PIXEL_DEPTH-1:0]             threshold,
  input  logic [$clog2(X_MAX)-1:0]           max_x,
  input  logic [$clog2(Y_MAX)-1:0]           max_y,
  output logic [$clog2(X_MAX):0]             x_addr_img,
  output logic [$clog2(Y_MAX):0]             y_addr_img,
  output logic                               ren_img,
  input  logic [PIXEL_DEPTH-1:0]             rdat_img,
  output logic [$clog2(X_MAX):0]             x_addr_out,
  output logic [$clog2(Y_MAX):0]             y_addr_out,
  output logic                               wen_out,
  output logic                               wdat_out,
  output logic                               busy,
  output logic                               det_done,
  output logic [$clog2(X_MAX*Y_MAX):0]       corner_count
);

  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int CW = $clog2(X_MAX*Y_MAX) + 1;
  localparam int PD = PIXEL_DEPTH;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EVAL, S_WRITE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, mx_q, mx_d;
  logic [YW-1:0]   y_q, y_d, my_q, my_d;
  logic [PD-1:0]   thr_q, thr_d;
  logic [4:0]      idx_q, idx_d;
  logic [PD-1:0]   pix_q [0:16];
  logic [PD-1:0]   pix_d [0:16];
  logic            corner_q, corner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [15:0]     bright, dark;
  logic            cur_int;
  logic signed [3:0] dx, dy;
  logic signed [XW:0] x_sum;
  logic signed [YW:0] y_sum;

  function automatic logic is_interior(input logic [XW-1:0] x, input logic [XW-1:0] mx,
                                       input logic [YW-1:0] y, input logic [YW-1:0] my);
    // With a dimension below 7 pixels the circle never fits, so no interior exists.
    return (mx >= XW'(6)) && (my >= YW'(6)) &&
           (x >= XW'(3)) && (x <= mx - XW'(3)) &&
           (y >= YW'(3)) && (y <= my - YW'(3));
  endfunction

  function automatic logic signed [3:0] off_dx(input logic [3:0] pos);
    case (pos)
      4'd0, 4'd8:                off_dx = 4'sd0;
      4'd1, 4'd7:                off_dx = 4'sd1;
      4'd2, 4'd6:                off_dx = 4'sd2;
      4'd3, 4'd4, 4'd5:          off_dx = 4'sd3;
      4'd9, 4'd15:               off_dx = -4'sd1;
      4'd10, 4'd14:              off_dx = -4'sd2;
      default:                   off_dx = -4'sd3;
    endcase
  endfunction

  function automatic logic signed [3:0] off_dy(input logic [3:0] pos);
    case (pos)
      4'd0, 4'd1, 4'd15:         off_dy = -4'sd3;
      4'd2, 4'd14:               off_dy = -4'sd2;
      4'd3, 4'd13:               off_dy = -4'sd1;
      4'd4, 4'd12:               off_dy = 4'sd0;
      4'd5, 4'd11:               off_dy = 4'sd1;
      4'd6, 4'd10:               off_dy = 4'sd2;
      default:                   off_dy = 4'sd3;
    endcase
  endfunction

  // True when some window of ARC_LEN circularly adjacent bits is all ones.
  function automatic logic has_arc(input logic [15:0] v);
    logic hit;
    logic run;
    logic [3:0] j;
    hit = 1'b0;
    for (int s = 0; s < 16; s++) begin
      run = 1'b1;
      for (int k = 0; k < ARC_LEN; k++) begin
        j   = 4'(s + k);
        run = run & v[j];
      end
      hit = hit | run;
    end
    return hit;
  endfunction

  // Read address: index 0 is the centre, index n>0 is circle position n-1.
  always_comb begin
    logic [3:0] pos;
    pos   = 4'(idx_q - 5'd1);
    dx    = (idx_q == 5'd0) ? 4'sd0 : off_dx(pos);
    dy    = (idx_q == 5'd0) ? 4'sd0 : off_dy(pos);
    x_sum = $signed({1'b0, x_q}) + $signed({{(XW-3){dx[3]}}, dx});
    y_sum = $signed({1'b0, y_q}) + $signed({{(YW-3){dy[3]}}, dy});
  end

  // Comparisons carried at PD+1 bits so c+t and p+t can never wrap.
  always_comb begin
    logic [PD:0] c_ext, t_ext, p_ext;
    c_ext = {1'b0, pix_q[0]};
    t_ext = {1'b0, thr_q};
    for (int i = 0; i < 16; i++) begin
      p_ext     = {1'b0, pix_q[i+1]};
      bright[i] = p_ext > (c_ext + t_ext);
      dark[i]   = (p_ext + t_ext) < c_ext;
    end
  end

  assign cur_int = is_interior(x_q, mx_q, y_q, my_q);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mx_d     = mx_q;
    my_d     = my_q;
    thr_d    = thr_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    corner_d = corner_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (new_trans) begin
          thr_d   = threshold;
          mx_d    = max_x;
          my_d    = max_y;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = is_interior('0, max_x, '0, max_y) ? S_FETCH : S_WRITE;
        end
      end
      S_FETCH: begin
        // Data for the read issued last cycle arrives now.
        if (idx_q != 5'd0) pix_d[idx_q - 5'd1] = rdat_img;
        if (idx_q == 5'd16) state_d = S_WAIT;
        else                idx_d   = idx_q + 5'd1;
      end
      S_WAIT: begin
        pix_d[16] = rdat_img;
        state_d   = S_EVAL;
      end
      S_EVAL: begin
        corner_d = has_arc(bright) | has_arc(dark);
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (cur_int && corner_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if ((x_q == mx_q) && (y_q == my_q)) begin
          state_d = S_DONE;
        end else begin
          if (x_q == mx_q) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          idx_d   = '0;
          state_d = is_interior(x_d, mx_q, y_d, my_q) ? S_FETCH : S_WRITE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      corner_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      corner_q <= corner_d;
      cnt_q    <= cnt_d;
    end
  end

  // Datapath holding registers: only meaningful once a frame has started.
  always_ff @(posedge clk) begin
    mx_q  <= mx_d;
    my_q  <= my_d;
    thr_q <= thr_d;
    pix_q <= pix_d;
  end

  always_comb begin
    ren_img      = (state_q == S_FETCH);
    wen_out      = (state_q == S_WRITE);
    x_addr_img   = ren_img ? x_sum[XW:0] : '0;
    y_addr_img   = ren_img ? y_sum[YW:0] : '0;
    x_addr_out   = wen_out ? {1'b0, x_q} : '0;
    y_addr_out   = wen_out ? {1'b0, y_q} : '0;
    wdat_out     = wen_out && cur_int && corner_q;
    busy         = (state_q != S_IDLE);
    det_done     = (state_q == S_DONE);
    corner_count = cnt_q;
  end

endmodule

// File: tb/tb_fast_detect.sv
// Bench for fast_detect: a memory model serves the image, and a reference
// schedule built from the frame-walking and corner rules predicts every
// output on every cycle of a frame.
module tb_fast_detect;
  localparam int XW = 8;
  localparam int YW = 8;
  localparam int CW = 17;
  localparam int N  = 16;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst, new_trans;
  logic [7:0] threshold, rdat_img;
  logic [XW-1:0] max_x;
  logic [YW-1:0] max_y;
  logic [XW:0] x_addr_img, x_addr_out;
  logic [YW:0] y_addr_img, y_addr_out;
  logic ren_img, wen_out, wdat_out, busy, det_done;
  logic [CW-1:0] corner_count;

  fast_detect dut (
    .clk(clk), .rst(rst), .new_trans(new_trans), .threshold(threshold),
    .max_x(max_x), .max_y(max_y), .x_addr_img(x_addr_img), .y_addr_img(y_addr_img),
    .ren_img(ren_img), .rdat_img(rdat_img), .x_addr_out(x_addr_out),
    .y_addr_out(y_addr_out), .wen_out(wen_out), .wdat_out(wdat_out),
    .busy(busy), .det_done(det_done), .corner_count(corner_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int img [0:N-1][0:N-1];
  int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  function automatic logic [7:0] pix_at(input int x, input int y);
    if (x >= 0 && x < N && y >= 0 && y < N) return 8'(img[y][x]);
    return 8'h00;
  endfunction

  always @(posedge clk) if (ren_img) rdat_img <= pix_at(int'(x_addr_img), int'(y_addr_img));

  function automatic bit inside_px(input int x, input int y, input int mx, input int my);
    return mx >= 6 && my >= 6 && x >= 3 && x <= mx - 3 && y >= 3 && y <= my - 3;
  endfunction

  // Walk the circle twice so a run crossing position 15->0 is seen whole.
  function automatic bit model_corner(input int x, input int y, input int thr);
    int c, p, rb, rd;
    c = img[y][x];
    rb = 0;
    rd = 0;
    for (int i = 0; i < 32; i++) begin
      p = img[y + DY[i % 16]][x + DX[i % 16]];
      rb = (p > c + thr) ? rb + 1 : 0;
      rd = (p + thr < c) ? rd + 1 : 0;
      if (rb >= 9 || rd >= 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] pack(input bit ren, input int xa, input int ya, input bit wen,
                                       input int xo, input int yo, input bit wd, input bit bz,
                                       input bit dn, input int cnt);
    return {6'b0, ren, 9'(xa), 9'(ya), wen, 9'(xo), 9'(yo), wd, bz, dn, 17'(cnt)};
  endfunction

  logic [63:0] expv [0:MAXC-1];
  bit          eren [0:MAXC-1];
  bit          ewen [0:MAXC-1];

  task automatic fill(input int v);
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) img[y][x] = v;
  endtask

  task automatic ring(input int x, input int y, input int val, input int from, input int len);
    int p;
    for (int k = 0; k < len; k++) begin
      p = (from + k) % 16;
      img[y + DY[p]][x + DX[p]] = val;
    end
  endtask

  task automatic rand_img();
    int bx, by, v;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) img[y][x] = int'($urandom_range(90, 110));
    for (int b = 0; b < 4; b++) begin
      bx = int'($urandom_range(0, N - 2));
      by = int'($urandom_range(0, N - 2));
      v = ($urandom_range(0, 1) == 1) ? 230 : 0;
      img[by][bx] = v;
      if ($urandom_range(0, 1) == 1) begin
        img[by][bx+1] = v;
        img[by+1][bx] = v;
        img[by+1][bx+1] = v;
      end
    end
  endtask

  // Runs one frame starting at cycle 0 (new_trans high); checks every cycle
  // through one cycle past completion. poke>0 pulses new_trans in that cycle.
  task automatic run_frame(input int mx, input int my, input int thr, input int poke,
                           output int dseen, output bit f44, output int cnt_end);
    int t, cnt, done;
    bit wd;
    logic [63:0] got;
    t = 1;
    cnt = 0;
    for (int y = 0; y <= my; y++) begin
      for (int x = 0; x <= mx; x++) begin
        if (inside_px(x, y, mx, my)) begin
          for (int k = 0; k < 17; k++) begin
            expv[t+k] = pack(1, (k == 0) ? x : x + DX[k-1], (k == 0) ? y : y + DY[k-1],
                             0, 0, 0, 0, 1, 0, cnt);
            eren[t+k] = 1; ewen[t+k] = 0;
          end
          for (int k = 17; k < 19; k++) begin
            expv[t+k] = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, cnt);
            eren[t+k] = 0; ewen[t+k] = 0;
          end
          wd = model_corner(x, y, thr);
          expv[t+19] = pack(0, 0, 0, 1, x, y, wd, 1, 0, cnt);
          eren[t+19] = 0; ewen[t+19] = 1;
          if (wd) cnt++;
          t += 20;
        end else begin
          expv[t] = pack(0, 0, 0, 1, x, y, 0, 1, 0, cnt);
          eren[t] = 0; ewen[t] = 1;
          t += 1;
        end
      end
    end
    done = t;
    expv[done] = pack(0, 0, 0, 0, 0, 0, 0, 1, 1, cnt);
    expv[done+1] = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
    eren[done] = 0; ewen[done] = 0; eren[done+1] = 0; ewen[done+1] = 0;

    dseen = -1;
    f44 = 1'b0;
    @(negedge clk);
    threshold = 8'(thr);
    max_x = XW'(mx);
    max_y = YW'(my);
    new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    for (int c = 1; c <= done + 1; c++) begin
      got = pack(ren_img, eren[c] ? int'(x_addr_img) : 0, eren[c] ? int'(y_addr_img) : 0,
                 wen_out, ewen[c] ? int'(x_addr_out) : 0, ewen[c] ? int'(y_addr_out) : 0,
                 wdat_out, busy, det_done, int'(corner_count));
      check($sformatf("cyc%0d", c), got, expv[c]);
      if (det_done && dseen < 0) dseen = c;
      if (wen_out && x_addr_out == 9'd4 && y_addr_out == 9'd4) f44 = wdat_out;
      new_trans = (c == poke);
      @(negedge clk);
    end
    new_trans = 1'b0;
    cnt_end = int'(corner_count);
  endtask

  function automatic logic [63:0] all_out();
    return pack(ren_img, int'(x_addr_img), int'(y_addr_img), wen_out, int'(x_addr_out),
                int'(y_addr_out), wdat_out, busy, det_done, int'(corner_count));
  endfunction

  initial begin
    int d, ce, mx, my, thr;
    bit f;
    bit seen;
    rst = 1'b1;
    new_trans = 1'b0;
    threshold = 8'd0;
    max_x = '0;
    max_y = '0;
    repeat (3) @(negedge clk);
    check("reset_state", all_out(), 64'd0);
    rst = 1'b0;

    // Flat 9x9 frame.
    fill(100);
    run_frame(8, 8, 20, 0, d, f, ce);
    check("flat_done_cycle", d, 253);
    check("flat_count", ce, 0);

    // Single bright pixel in the middle.
    img[4][4] = 200;
    run_frame(8, 8, 20, 0, d, f, ce);
    check("spot_flag", f, 1);
    check("spot_count", ce, 1);

    // Wrapping arc of 9, then of 8.
    fill(100);
    ring(4, 4, 150, 12, 9);
    run_frame(8, 8, 20, 0, d, f, ce);
    check("arc9_wrap", f, 1);
    fill(100);
    ring(4, 4, 150, 13, 8);
    run_frame(8, 8, 20, 0, d, f, ce);
    check("arc8_wrap", f, 0);

    // Threshold edges and no underflow.
    fill(100);
    ring(4, 4, 120, 0, 16);
    run_frame(8, 8, 20, 0, d, f, ce);
    check("thr_equal", f, 0);
    fill(100);
    ring(4, 4, 121, 0, 16);
    run_frame(8, 8, 20, 0, d, f, ce);
    check("thr_above", f, 1);
    fill(10);
    ring(4, 4, 0, 0, 16);
    run_frame(8, 8, 20, 0, d, f, ce);
    check("dark_no_underflow", f, 0);

    // Start pulse while busy must be ignored.
    rand_img();
    img[4][4] = 230;
    run_frame(10, 9, 15, 30, d, f, ce);
    run_frame(8, 8, 20, 252, d, f, ce);
    check("poke_done_cycle", d, 253);

    // Reset in the middle of a fetch, then a fresh frame.
    fill(100);
    img[4][4] = 200;
    @(negedge clk);
    threshold = 8'd20;
    max_x = 8'd8;
    max_y = 8'd8;
    new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (ren_img) seen = 1'b1;
      else @(negedge clk);
    end
    check("fetch_reached", seen, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_fetch", all_out(), 64'd0);
    rst = 1'b0;
    run_frame(8, 8, 20, 0, d, f, ce);
    check("after_reset_flag", f, 1);
    check("after_reset_done", d, 253);

    // Randomised frames, including sizes with no interior.
    for (int r = 0; r < 8; r++) begin
      rand_img();
      mx = int'($urandom_range(2, N - 1));
      my = int'($urandom_range(2, N - 1));
      thr = int'($urandom_range(5, 40));
      run_frame(mx, my, thr, (r % 2 == 1) ? int'($urandom_range(1, 40)) : 0, d, f, ce);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
